// File: rtl/fsm_3segment_mealy_if.sv
// rtl/fsm_3segment_mealy_if.sv - serial bit in, detect flag and state code out
interface fsm_3segment_mealy_if;
   logic       A;
   logic       Z;
   logic [1:0] y;

   modport master (output A, input Z, input y);
   modport slave  (input A, output Z, output y);
endinterface

// File: rtl/fsm_3segment_mealy.sv
// rtl/fsm_3segment_mealy.sv - overlapping "1011" detector, 3-segment Mealy FSM
module fsm_3segment_mealy (
   input logic                 clk,
   input logic                 rst,
   fsm_3segment_mealy_if.slave bus
);

   typedef enum logic [1:0] {
      S0 = 2'b00,
      S1 = 2'b01,
      S2 = 2'b10,
      S3 = 2'b11
   } state_t;

   state_t state;
   state_t state_nxt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S0;
      end else begin
         state <= state_nxt;
      end
   end

   // S3 falls back to S2/S1 rather than S0 so overlapping matches are kept
   always_comb begin
      state_nxt = S0;
      case (state)
         S0:      state_nxt = bus.A ? S1 : S0;
         S1:      state_nxt = bus.A ? S1 : S2;
         S2:      state_nxt = bus.A ? S3 : S0;
         S3:      state_nxt = bus.A ? S1 : S2;
         default: state_nxt = S0;
      endcase
   end

   always_comb begin
      bus.Z = 1'b0;
      case (state)
         S3:      bus.Z = bus.A;
         default: bus.Z = 1'b0;
      endcase
   end

   assign bus.y = state;

endmodule

// File: tb/tb_fsm_3segment_mealy.sv
// tb/tb_fsm_3segment_mealy.sv - scoreboard bench for the "1011" Mealy detector
module tb_fsm_3segment_mealy;

   logic clk;
   logic rst;

   fsm_3segment_mealy_if bus ();

   fsm_3segment_mealy dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       z;
      logic [1:0] y;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   logic [1:0] pend_y;
   string      pend_name;
   bit         pend_v = 1'b0;

   // Drive one bit just after the edge; Z is expected for this cycle, y after the next edge
   task automatic step(input logic r, input logic a, input logic ez, input logic [1:0] ey, input string nm);
      exp_t e;
      @(posedge clk);
      #2;
      rst   = r;
      bus.A = a;
      e.z    = ez;
      e.y    = ey;
      e.name = nm;
      sb.push_back(e);
   endtask

   // Monitor: at each falling edge, settle the pending y check, then check Z of the current bit
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (pend_v) begin
            checks++;
            if (bus.y !== pend_y) begin
               errors++;
               $display("FAIL %s_y: got %b expected %b", pend_name, bus.y, pend_y);
            end
            pend_v = 1'b0;
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (bus.Z !== e.z) begin
               errors++;
               $display("FAIL %s_z: got %b expected %b", e.name, bus.Z, e.z);
            end
            pend_y    = e.y;
            pend_name = e.name;
            pend_v    = 1'b1;
         end
      end
   end

   initial begin
      int wait_cycles;
      rst   = 1'b0;
      bus.A = 1'b0;

      // Test 1: reset with A=1 then A=0
      step(1'b0, 1'b1, 1'b0, 2'b00, "rst_a1");
      step(1'b0, 1'b0, 1'b0, 2'b00, "rst_a0");

      // Test 2: 1,0,1,0
      step(1'b1, 1'b1, 1'b0, 2'b01, "t2_b1");
      step(1'b1, 1'b0, 1'b0, 2'b10, "t2_b2");
      step(1'b1, 1'b1, 1'b0, 2'b11, "t2_b3");
      step(1'b1, 1'b0, 1'b0, 2'b10, "t2_b4");
      step(1'b0, 1'b0, 1'b0, 2'b00, "t2_rst");

      // Test 3: 1,0,1,0,1,1,1 -> single detect on bit 6
      step(1'b1, 1'b1, 1'b0, 2'b01, "t3_b1");
      step(1'b1, 1'b0, 1'b0, 2'b10, "t3_b2");
      step(1'b1, 1'b1, 1'b0, 2'b11, "t3_b3");
      step(1'b1, 1'b0, 1'b0, 2'b10, "t3_b4");
      step(1'b1, 1'b1, 1'b0, 2'b11, "t3_b5");
      step(1'b1, 1'b1, 1'b1, 2'b01, "t3_b6");
      step(1'b1, 1'b1, 1'b0, 2'b01, "t3_b7");
      step(1'b0, 1'b0, 1'b0, 2'b00, "t3_rst");

      // Test 4: overlap 1,0,1,1,0,1,1 -> detects on bits 4 and 7
      step(1'b1, 1'b1, 1'b0, 2'b01, "t4_b1");
      step(1'b1, 1'b0, 1'b0, 2'b10, "t4_b2");
      step(1'b1, 1'b1, 1'b0, 2'b11, "t4_b3");
      step(1'b1, 1'b1, 1'b1, 2'b01, "t4_b4");
      step(1'b1, 1'b0, 1'b0, 2'b10, "t4_b5");
      step(1'b1, 1'b1, 1'b0, 2'b11, "t4_b6");
      step(1'b1, 1'b1, 1'b1, 2'b01, "t4_b7");
      step(1'b0, 1'b0, 1'b0, 2'b00, "t4_rst");

      // Test 5: eight zeros, then eight ones
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 2'b00, "t5_zero");
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 2'b01, "t5_one");
      step(1'b0, 1'b0, 1'b0, 2'b00, "t5_rst");

      // Test 6: reset in the middle of a match
      step(1'b1, 1'b1, 1'b0, 2'b01, "t6_b1");
      step(1'b1, 1'b0, 1'b0, 2'b10, "t6_b2");
      step(1'b1, 1'b1, 1'b0, 2'b11, "t6_b3");
      step(1'b0, 1'b0, 1'b0, 2'b00, "t6_rst");
      step(1'b1, 1'b1, 1'b0, 2'b01, "t6_after");

      wait_cycles = 0;
      while ((sb.size() > 0 || pend_v) && wait_cycles < 20) begin
         @(posedge clk);
         wait_cycles++;
      end
      if (sb.size() > 0 || pend_v) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
